// File: rtl/board_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : board_move_engine
// Purpose  : 4x4 board register with slide/merge moves, one line per clock,
//            plus score accumulator and sticky win flag.
// Revision : 1.0  initial release
// ============================================================================
module board_move_engine #(
  parameter int WIN_EXP = 11,
  parameter int SCORE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               gen_busy,
  input  logic               ld,
  input  logic [63:0]        ld_board,
  output logic [63:0]        board,
  output logic               busy,
  output logic               done,
  output logic               moved,
  output logic [SCORE_W-1:0] score,
  output logic               win
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LINE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_dir_up    = 2'd0;
  localparam logic [1:0] c_dir_down  = 2'd1;
  localparam logic [1:0] c_dir_left  = 2'd2;
  localparam logic [1:0] c_dir_right = 2'd3;
  localparam logic [4:0] c_win_exp   = 5'(WIN_EXP);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [63:0]        r_board;
  logic [SCORE_W-1:0] r_score;
  logic               r_win;
  logic               r_changed;
  logic [1:0]         r_dir;
  logic [1:0]         r_idx;
  logic [3:0]         r_prev;

  logic [3:0]         w_btn;
  logic [3:0]         w_edge;
  logic [1:0]         w_dir_sel;
  logic               w_accept;
  logic [3:0]         w_pos [4];
  logic [15:0]        w_old;
  logic [15:0]        w_cmp;
  logic [15:0]        w_mrg;
  logic [15:0]        w_new;
  logic [SCORE_W-1:0] w_gain;
  logic               w_win_hit;
  logic               w_line_chg;

  // Packs the non-empty tiles of a line toward element 0.
  function automatic logic [15:0] f_compact(input logic [15:0] l);
    logic [15:0] o;
    logic [1:0]  k;
    o = '0;
    k = '0;
    for (int j = 0; j < 4; j++) begin
      if (l[4*j +: 4] != 4'd0) begin
        o[{k, 2'b00} +: 4] = l[4*j +: 4];
        k = k + 2'd1;
      end
    end
    return o;
  endfunction

  assign w_btn  = {up, down, left, right};
  assign w_edge = w_btn & ~r_prev;

  always_comb begin
    w_dir_sel = c_dir_right;
    if (w_edge[3])      w_dir_sel = c_dir_up;
    else if (w_edge[2]) w_dir_sel = c_dir_down;
    else if (w_edge[1]) w_dir_sel = c_dir_left;
  end

  assign w_accept = (r_state == S_IDLE) && !gen_busy && !ld && (w_edge != 4'b0000);

  // Board tile index of each line element; element 0 is the leading edge.
  always_comb begin
    w_old = '0;
    for (int j = 0; j < 4; j++) begin
      case (r_dir)
        c_dir_left:  w_pos[j] = {r_idx, 2'(j)};
        c_dir_right: w_pos[j] = {r_idx, 2'(3 - j)};
        c_dir_up:    w_pos[j] = {2'(j), r_idx};
        default:     w_pos[j] = {2'(3 - j), r_idx};
      endcase
      w_old[4*j +: 4] = r_board[{w_pos[j], 2'b00} +: 4];
    end
  end

  assign w_cmp = f_compact(w_old);

  // A merged tile's partner is skipped so nothing merges twice in a move.
  always_comb begin
    logic       skip;
    logic [4:0] e;
    w_mrg     = w_cmp;
    w_gain    = '0;
    w_win_hit = 1'b0;
    skip      = 1'b0;
    e         = '0;
    for (int j = 0; j < 3; j++) begin
      e = {1'b0, w_cmp[4*j +: 4]} + 5'd1;
      if (skip) begin
        skip = 1'b0;
      end else if (w_cmp[4*j +: 4] != 4'd0 &&
                   w_cmp[4*j +: 4] == w_cmp[4*(j+1) +: 4] &&
                   w_cmp[4*j +: 4] != 4'hF) begin
        w_mrg[4*j +: 4]     = e[3:0];
        w_mrg[4*(j+1) +: 4] = 4'd0;
        skip                = 1'b1;
        w_gain              = w_gain + (SCORE_W'(1) << e);
        if (e >= c_win_exp) w_win_hit = 1'b1;
      end
    end
  end

  assign w_new      = f_compact(w_mrg);
  assign w_line_chg = (w_new != w_old);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_board   <= '0;
      r_score   <= '0;
      r_win     <= 1'b0;
      r_changed <= 1'b0;
      r_dir     <= c_dir_up;
      r_idx     <= 2'd0;
      r_prev    <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_btn;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir     <= w_dir_sel;
            r_idx     <= 2'd0;
            r_changed <= 1'b0;
          end else if (ld) begin
            r_board <= ld_board;
          end
        end
        S_LINE: begin
          for (int j = 0; j < 4; j++) begin
            r_board[{w_pos[j], 2'b00} +: 4] <= w_new[4*j +: 4];
          end
          r_idx     <= r_idx + 2'd1;
          r_changed <= r_changed | w_line_chg;
          r_score   <= r_score + w_gain;
          if (w_win_hit) r_win <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    moved       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_LINE;
      S_LINE: begin
        busy = 1'b1;
        if (r_idx == 2'd3) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        moved       = r_changed;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign board = r_board;
  assign score = r_score;
  assign win   = r_win;

endmodule
`default_nettype wire

// File: tb/tb_board_move_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_move_engine
// Purpose  : Directed vector bench for board_move_engine.
// Revision : 1.0  initial release
// ============================================================================
module tb_board_move_engine;

  localparam int SCORE_W = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic               up, down, left, right;
  logic               gen_busy;
  logic               ld;
  logic [63:0]        ld_board;
  logic [63:0]        board;
  logic               busy, done, moved, win;
  logic [SCORE_W-1:0] score;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0]        init;
    int                 dir;  // 0 up, 1 down, 2 left, 3 right
    logic [63:0]        exp_board;
    logic [SCORE_W-1:0] exp_score;
    logic               exp_moved;
    logic               exp_win;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  board_move_engine #(.WIN_EXP(11), .SCORE_W(SCORE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .gen_busy (gen_busy),
    .ld       (ld),
    .ld_board (ld_board),
    .board    (board),
    .busy     (busy),
    .done     (done),
    .moved    (moved),
    .score    (score),
    .win      (win)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0:       up    = v;
      1:       down  = v;
      2:       left  = v;
      default: right = v;
    endcase
  endtask

  task automatic load(input logic [63:0] b);
    @(negedge clk);
    ld       = 1'b1;
    ld_board = b;
    @(negedge clk);
    ld       = 1'b0;
  endtask

  // Pulse a button for one cycle; report done latency (in negedges after the
  // accepting edge), busy samples and moved at the done sample.
  task automatic do_move(input int d, output int lat, output int bcnt, output logic mv);
    logic seen;
    @(negedge clk);
    set_btn(d, 1'b1);
    @(negedge clk);
    set_btn(d, 1'b0);
    lat  = 0;
    bcnt = 0;
    mv   = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      if (busy) bcnt++;
      if (done) begin
        lat  = c;
        mv   = moved;
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat, bcnt, cnt;
    logic mv;

    vecs[0] = '{64'h0000_0000_0000_1111, 2, 64'h0000_0000_0000_0022, 24'd8,    1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_3202, 2, 64'h0000_0000_0000_0033, 24'd16,   1'b1, 1'b0};
    vecs[2] = '{64'h0000_0002_0001_0001, 1, 64'h0002_0002_0000_0000, 24'd20,   1'b1, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_4321, 0, 64'h0000_0000_0000_4321, 24'd20,   1'b0, 1'b0};
    vecs[4] = '{64'h0000_0000_2211_0000, 3, 64'h0000_0000_3200_0000, 24'd32,   1'b1, 1'b0};
    vecs[5] = '{64'h0500_0500_0500_0500, 0, 64'h0000_0000_0600_0600, 24'd160,  1'b1, 1'b0};
    vecs[6] = '{64'h00FF_0000_0000_0000, 2, 64'h00FF_0000_0000_0000, 24'd160,  1'b0, 1'b0};
    vecs[7] = '{64'h2000_2000_0000_2000, 1, 64'h3000_2000_0000_0000, 24'd168,  1'b1, 1'b0};
    vecs[8] = '{64'h0000_0000_0000_00AA, 3, 64'h0000_0000_0000_B000, 24'd2216, 1'b1, 1'b1};

    rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    gen_busy = 1'b0; ld = 1'b0; ld_board = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset board", board, 64'h0);
    check("reset score", 64'(score), 64'h0);
    check("reset busy",  64'(busy), 64'h0);
    check("reset done",  64'(done), 64'h0);
    check("reset win",   64'(win), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      load(vecs[i].init);
      do_move(vecs[i].dir, lat, bcnt, mv);
      check($sformatf("v%0d latency", i),  64'(lat),  64'd5);
      check($sformatf("v%0d busy_cyc", i), 64'(bcnt), 64'd5);
      check($sformatf("v%0d moved", i),    64'(mv),   64'(vecs[i].exp_moved));
      check($sformatf("v%0d board", i),    board,     vecs[i].exp_board);
      check($sformatf("v%0d score", i),    64'(score), 64'(vecs[i].exp_score));
      check($sformatf("v%0d win", i),      64'(win),  64'(vecs[i].exp_win));
    end

    // Win is sticky across a load
    load(64'h0);
    check("win after ld", 64'(win), 64'd1);
    check("ld zero board", board, 64'h0);

    // Simultaneous up/left: up wins
    load(64'h0000_0000_0010_0000);
    @(negedge clk);
    up = 1'b1; left = 1'b1;
    @(negedge clk);
    up = 1'b0; left = 1'b0;
    count_done(8, cnt);
    check("prio done cnt", 64'(cnt), 64'd1);
    check("prio board", board, 64'h0000_0000_0000_0010);

    // Press while generator busy is dropped
    load(64'h0000_0000_0000_0001);
    @(negedge clk);
    gen_busy = 1'b1;
    down     = 1'b1;
    @(negedge clk);
    down     = 1'b0;
    count_done(8, cnt);
    gen_busy = 1'b0;
    check("genbusy done cnt", 64'(cnt), 64'd0);
    check("genbusy board", board, 64'h0000_0000_0000_0001);

    // Second button pressed mid-move is dropped
    load(64'h0000_0000_0000_0100);
    @(negedge clk);
    left = 1'b1;
    @(negedge clk);
    left = 1'b0;
    @(negedge clk);
    right = 1'b1;
    count_done(12, cnt);
    right = 1'b0;
    check("midmove done cnt", 64'(cnt), 64'd1);
    check("midmove board", board, 64'h0000_0000_0000_0001);

    // Held button gives a single move
    load(64'h0000_0000_0000_0100);
    @(negedge clk);
    left = 1'b1;
    count_done(20, cnt);
    left = 1'b0;
    check("held done cnt", 64'(cnt), 64'd1);
    check("held board", board, 64'h0000_0000_0000_0001);

    // Async reset in the middle of LINE aborts the move
    load(64'h0000_0000_0000_1111);
    @(negedge clk);
    left = 1'b1;
    @(negedge clk);
    left = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst board", board, 64'h0);
    check("midrst score", 64'(score), 64'h0);
    check("midrst busy",  64'(busy), 64'h0);
    check("midrst win",   64'(win), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    count_done(8, cnt);
    check("midrst done cnt", 64'(cnt), 64'd0);

    // Normal operation after the abort
    load(64'h0000_0000_0000_1111);
    do_move(2, lat, bcnt, mv);
    check("post latency", 64'(lat), 64'd5);
    check("post moved",   64'(mv), 64'd1);
    check("post board",   board, 64'h0000_0000_0000_0022);
    check("post score",   64'(score), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
